// File: rtl/calc_pkg.sv
// calc_pkg: command opcodes and issuer FSM states shared by the issuer and the memory controller.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_MUL  = 3'd4,
        OP_DIV  = 3'd5
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_HOLD    = 2'd3
    } issuer_state_e;

endpackage

// File: rtl/btn_edge_pick.sv
// btn_edge_pick: rising-edge detect on debounced buttons with lowest-index priority select.
module btn_edge_pick
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn_db,
    output logic       pick_valid,
    output logic [2:0] pick_op
);

    logic [4:0] prev;
    logic       armed;
    logic [4:0] rise;

    // armed masks the first cycle after reset so a button held through reset is not an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            prev  <= btn_db;
            armed <= 1'b1;
        end
    end

    always_comb begin
        rise       = armed ? (btn_db & ~prev) : 5'd0;
        pick_valid = |rise;
        pick_op    = OP_NOP;
        for (int i = 4; i >= 0; i--)
            if (rise[i]) pick_op = 3'(i + 1);
    end

endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: turns button presses into valid/ready commands for the memory controller.
// Optional auto-repeat while a single button is held: define CMD_AUTOREPEAT_EN.
module cmd_issuer
    import calc_pkg::*;
#(
    parameter int unsigned REPEAT_DLY  = 50_000_000,
    parameter int unsigned REPEAT_RATE = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn_db,
    input  logic [15:0] switches,
    input  logic        full,
    input  logic        empty,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [2:0]  cmd_op,
    output logic [15:0] cmd_data,
    output logic        busy,
    output logic        err
);

    issuer_state_e state, state_n;
    logic          valid_n, err_n, sel, reject, pick_valid;
    logic [2:0]    op_n, sel_op, pick_op;
    logic [15:0]   data_n;
`ifdef CMD_AUTOREPEAT_EN
    logic [31:0]   cnt, cnt_n;
    logic [4:0]    held;
    assign held = 5'd1 << (cmd_op - 3'd1);
`endif

    btn_edge_pick u_pick (
        .clk       (clk),
        .rst       (rst),
        .btn_db    (btn_db),
        .pick_valid(pick_valid),
        .pick_op   (pick_op)
    );

    assign busy = state != S_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_NOP;
            cmd_data  <= '0;
            err       <= 1'b0;
`ifdef CMD_AUTOREPEAT_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_n;
            cmd_valid <= valid_n;
            cmd_op    <= op_n;
            cmd_data  <= data_n;
            err       <= err_n;
`ifdef CMD_AUTOREPEAT_EN
            cnt       <= cnt_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        valid_n = cmd_valid;
        op_n    = cmd_op;
        data_n  = cmd_data;
        err_n   = err;
        sel     = 1'b0;
        sel_op  = pick_op;
`ifdef CMD_AUTOREPEAT_EN
        cnt_n   = cnt + 32'd1;
`endif
        case (state)
            S_IDLE: begin
                sel = pick_valid;
`ifdef CMD_AUTOREPEAT_EN
                cnt_n = 32'd1;
`endif
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    valid_n = 1'b0;
`ifdef CMD_AUTOREPEAT_EN
                    state_n = (btn_db == held) ? S_HOLD : S_RELEASE;
`else
                    state_n = S_RELEASE;
`endif
                end
            end
            S_RELEASE: state_n = (btn_db == 5'd0) ? S_IDLE : S_RELEASE;
`ifdef CMD_AUTOREPEAT_EN
            // cnt counts held cycles since the press; after a repeat it restarts so the next one is REPEAT_RATE away
            S_HOLD: begin
                if (btn_db != held) begin
                    state_n = S_RELEASE;
                end else if (cnt >= REPEAT_DLY - 32'd1) begin
                    sel    = 1'b1;
                    sel_op = cmd_op;
                    cnt_n  = REPEAT_DLY - REPEAT_RATE;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
        reject = (sel_op == OP_PUSH) ? full : empty;
        if (sel) begin
            err_n   = reject;
            valid_n = !reject;
            state_n = reject ? S_RELEASE : S_ISSUE;
            op_n    = reject ? cmd_op : sel_op;
            data_n  = reject ? cmd_data : ((sel_op == OP_PUSH) ? switches : 16'd0);
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// tb_cmd_issuer: directed stimulus checked every cycle against a transaction-level model of the issuer.
module tb_cmd_issuer;

    localparam int DLY  = 20;
    localparam int RATE = 5;
`ifdef CMD_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  btn_db = '0;
    logic [15:0] switches = '0;
    logic        full = 1'b0;
    logic        empty = 1'b0;
    logic        cmd_ready = 1'b1;
    logic        cmd_valid, busy, err;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_data;

    int n_vec = 0;
    int n_err = 0;
    int xfers = 0;

    cmd_issuer #(.REPEAT_DLY(DLY), .REPEAT_RATE(RATE)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_db   (btn_db),
        .switches (switches),
        .full     (full),
        .empty    (empty),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [4:0] onehot(input logic [2:0] op);
        return 5'd1 << (op - 3'd1);
    endfunction

    // model: mode 0 waiting for a press, 1 command outstanding, 2 waiting for release, 3 holding for repeat
    int          m_mode = 0;
    bit          m_valid = 1'b0;
    bit          m_err = 1'b0;
    bit          m_armed = 1'b0;
    logic [2:0]  m_op = '0;
    logic [15:0] m_data = '0;
    logic [4:0]  m_prev = '0;
    int          cyc = 0;
    int          next_sel = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_valid = 1'b0; m_err = 1'b0; m_armed = 1'b0;
            m_op = '0; m_data = '0; m_prev = '0;
        end else begin
            logic [4:0] rise;
            int sel;
            bit rej;
            rise = m_armed ? (btn_db & ~m_prev) : 5'd0;
            sel = 0;
            cyc++;
            case (m_mode)
                0: begin
                    for (int i = 4; i >= 0; i--) if (rise[i]) sel = i + 1;
                    if (sel != 0) next_sel = cyc + DLY - 1;
                end
                1: if (cmd_ready) begin
                    m_valid = 1'b0;
                    m_mode = (AR && btn_db == onehot(m_op)) ? 3 : 2;
                end
                2: if (btn_db == 5'd0) m_mode = 0;
                3: if (btn_db != onehot(m_op)) m_mode = 2;
                   else if (cyc >= next_sel) begin
                       sel = int'(m_op);
                       next_sel = cyc + RATE;
                   end
                default: m_mode = 0;
            endcase
            if (sel != 0) begin
                rej = (sel == 1) ? full : empty;
                m_err = rej;
                m_valid = !rej;
                m_mode = rej ? 2 : 1;
                if (!rej) begin
                    m_op = 3'(sel);
                    m_data = (sel == 1) ? switches : 16'd0;
                end
            end
            m_prev = btn_db;
            m_armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("valid", 32'(cmd_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("err", 32'(err), 32'(m_err));
        if (m_valid) begin
            check("op", 32'(cmd_op), 32'(m_op));
            check("data", 32'(cmd_data), 32'(m_data));
        end
    end

    always @(posedge clk) if (rst && cmd_valid && cmd_ready) xfers++;

    initial begin
        int x0;
        #3;
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_op", 32'(cmd_op), 32'd0);
        check("rst_data", 32'(cmd_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(2);

        // single push, immediate accept, held afterwards
        switches = 16'h00A5; cmd_ready = 1'b1; x0 = xfers;
        btn_db = 5'b00001;
        tick(1);
        check("push_valid", 32'(cmd_valid), 32'd1);
        check("push_op", 32'(cmd_op), 32'd1);
        check("push_data", 32'(cmd_data), 32'h00A5);
        tick(1);
        check("push_drop", 32'(cmd_valid), 32'd0);
        tick(5);
        check("push_once", 32'(xfers - x0), 32'd1);
        btn_db = '0;
        tick(2);

        // simultaneous add+sub edges: add wins
        x0 = xfers;
        btn_db = 5'b00110;
        tick(1);
        check("simul_op", 32'(cmd_op), 32'd2);
        check("simul_data", 32'(cmd_data), 32'd0);
        tick(3);
        check("simul_once", 32'(xfers - x0), 32'd1);
        btn_db = '0;
        tick(2);

        // backpressure with switches changing underneath
        x0 = xfers; cmd_ready = 1'b0;
        btn_db = 5'b00001;
        tick(1);
        switches = 16'hFFFF;
        tick(6);
        check("bp_valid", 32'(cmd_valid), 32'd1);
        check("bp_data", 32'(cmd_data), 32'h00A5);
        check("bp_none", 32'(xfers - x0), 32'd0);
        cmd_ready = 1'b1;
        tick(1);
        check("bp_xfer", 32'(xfers - x0), 32'd1);
        check("bp_drop", 32'(cmd_valid), 32'd0);
        btn_db = '0;
        tick(2);

        // rejections and err stickiness
        full = 1'b1;
        btn_db = 5'b00001;
        tick(1);
        check("full_valid", 32'(cmd_valid), 32'd0);
        check("full_err", 32'(err), 32'd1);
        btn_db = '0;
        tick(2);
        full = 1'b0;
        check("err_sticky", 32'(err), 32'd1);
        btn_db = 5'b01000;
        tick(1);
        check("mul_op", 32'(cmd_op), 32'd4);
        check("mul_err", 32'(err), 32'd0);
        tick(1);
        btn_db = '0;
        tick(2);
        empty = 1'b1;
        btn_db = 5'b10000;
        tick(1);
        check("div_err", 32'(err), 32'd1);
        check("div_valid", 32'(cmd_valid), 32'd0);
        btn_db = '0;
        tick(2);
        empty = 1'b0;

        // async reset while a command is stalled, button held through reset
        cmd_ready = 1'b0; switches = 16'h1234;
        btn_db = 5'b00001;
        tick(1);
        check("pre_rst_valid", 32'(cmd_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", 32'(cmd_valid), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_op", 32'(cmd_op), 32'd0);
        tick(2);
        rst = 1'b1; cmd_ready = 1'b1; x0 = xfers;
        tick(5);
        check("held_no_cmd", 32'(xfers - x0), 32'd0);
        btn_db = '0;
        tick(2);
        btn_db = 5'b00001;
        tick(1);
        check("repress_valid", 32'(cmd_valid), 32'd1);
        check("repress_data", 32'(cmd_data), 32'h1234);
        btn_db = '0;
        tick(3);

        // long hold: repeats only when auto-repeat is built in
        x0 = xfers;
        btn_db = 5'b00001;
        tick(37);
        btn_db = '0;
        tick(3);
        check("hold_xfers", 32'(xfers - x0), AR ? 32'd5 : 32'd1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
